// File: rtl/rvfi_mem_pkg.sv
// Shared types for the RVFI memory tracker: queue entry layout, error-bit indices, lane mask helper.
package rvfi_mem_pkg;
  localparam int MEM_XLEN = 32;
  localparam int MEM_NBE  = MEM_XLEN / 8;

  localparam int ERR_OVF    = 0;
  localparam int ERR_ORPHAN = 1;
  localparam int ERR_EMPTY  = 2;
  localparam int ERR_PEND   = 3;

  typedef struct packed {
    logic [MEM_XLEN-1:0] addr;
    logic [MEM_NBE-1:0]  rmask;
    logic [MEM_NBE-1:0]  wmask;
    logic [MEM_XLEN-1:0] rdata;
    logic [MEM_XLEN-1:0] wdata;
    logic                done;
  } mem_entry_t;

  function automatic logic [MEM_XLEN-1:0] lane_mask(input logic [MEM_NBE-1:0] be);
    lane_mask = '0;
    for (int i = 0; i < MEM_NBE; i++) lane_mask[i*8 +: 8] = {8{be[i]}};
  endfunction
endpackage

// File: rtl/rvfi_mem_queue.sv
// In-order circular buffer of bus transactions; loads wait PENDING until the oldest one is completed.
// Pointers carry one wrap bit; a third pointer always sits on the oldest PENDING entry (or at wptr).
module rvfi_mem_queue import rvfi_mem_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push_i,
  input  mem_entry_t          push_dat_i,
  input  logic                pop_i,
  input  logic                cmpl_i,
  input  logic [MEM_XLEN-1:0] cmpl_rdata_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                pend_o,
  output mem_entry_t          head_o
);
  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  mem_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q, pptr_q;
  logic [PTR_W-1:0] wptr_d, rptr_d, pptr_d;
  logic [PTR_W-1:0] scan_ptr;
  logic             found;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign pend_o  = (pptr_q != wptr_q);
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    rptr_d   = pop_i  ? rptr_q + 1'b1 : rptr_q;
    wptr_d   = push_i ? wptr_q + 1'b1 : wptr_q;
    pptr_d   = pptr_q;
    scan_ptr = '0;
    found    = 1'b0;
    // After a completion, skip forward over stores to the next load still waiting.
    if (cmpl_i) begin
      pptr_d = wptr_q;
      for (int k = 1; k < DEPTH; k++) begin
        scan_ptr = pptr_q + PTR_W'(k);
        if (!found && ((scan_ptr - rptr_q) < (wptr_q - rptr_q)) &&
            !mem_q[scan_ptr[PW-1:0]].done) begin
          found  = 1'b1;
          pptr_d = scan_ptr;
        end
      end
    end
    if (push_i && push_dat_i.done && (pptr_d == wptr_q)) pptr_d = wptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      pptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pptr_q <= pptr_d;
      if (cmpl_i) begin
        mem_q[pptr_q[PW-1:0]].rdata <= cmpl_rdata_i & lane_mask(mem_q[pptr_q[PW-1:0]].rmask);
        mem_q[pptr_q[PW-1:0]].done  <= 1'b1;
      end
      if (push_i) mem_q[wptr_q[PW-1:0]] <= push_dat_i;
    end
  end
endmodule

// File: rtl/rvfi_mem_tracker.sv
// Passive RVFI memory-field producer: queues bus transfers, pairs load responses, emits fields 1 cycle after retire.
// Never backpressures the bus; overflow/orphan/empty/pending faults set sticky err bits (asserts when RVFI_MEM_TRACKER_ASSERT_EN).
module rvfi_mem_tracker import rvfi_mem_pkg::*; #(
  parameter int XLEN    = MEM_XLEN,
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid_i,
  input  logic                 req_ready_i,
  input  logic                 req_rd_i,
  input  logic [XLEN-1:0]      req_addr_i,
  input  logic [XLEN/8-1:0]    req_be_i,
  input  logic [XLEN-1:0]      req_wdata_i,
  input  logic                 rsp_valid_i,
  input  logic [XLEN-1:0]      rsp_rdata_i,
  input  logic                 ret_valid_i,
  input  logic                 ret_mem_i,
  output logic                 rvfi_valid_o,
  output logic [ORDER_W-1:0]   rvfi_order_o,
  output logic [XLEN-1:0]      rvfi_mem_addr_o,
  output logic [XLEN/8-1:0]    rvfi_mem_rmask_o,
  output logic [XLEN/8-1:0]    rvfi_mem_wmask_o,
  output logic [XLEN-1:0]      rvfi_mem_rdata_o,
  output logic [XLEN-1:0]      rvfi_mem_wdata_o,
  output logic [3:0]           err_o
);
  localparam int NBE = XLEN / 8;

  logic       xfer, ret_mem_v, bypass, pop, push, cmpl;
  logic       full, empty, pend;
  mem_entry_t head, push_dat;
  logic [3:0] err_set;

  logic               valid_q;
  logic [ORDER_W-1:0] order_q, order_d, cnt_q, cnt_d;
  logic [XLEN-1:0]    addr_q, addr_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic [NBE-1:0]     rmask_q, rmask_d, wmask_q, wmask_d;
  logic [3:0]         err_q, err_d;

  assign xfer      = req_valid_i & req_ready_i;
  assign ret_mem_v = ret_valid_i & ret_mem_i;
  // A pending head is always the oldest pending entry, so a same-cycle response belongs to it.
  assign bypass    = ret_mem_v & ~empty & ~head.done & rsp_valid_i;
  assign pop       = ret_mem_v & ~empty & (head.done | rsp_valid_i);
  assign push      = xfer & (~full | pop);
  assign cmpl      = rsp_valid_i & pend;

  always_comb begin
    push_dat       = '0;
    push_dat.addr  = req_addr_i & ~XLEN'(NBE - 1);
    push_dat.done  = ~req_rd_i;
    push_dat.rmask = req_rd_i ? req_be_i : '0;
    push_dat.wmask = req_rd_i ? '0 : req_be_i;
    push_dat.wdata = req_rd_i ? '0 : (req_wdata_i & lane_mask(req_be_i));
  end

  always_comb begin
    err_set             = '0;
    err_set[ERR_OVF]    = xfer & full & ~pop;
    err_set[ERR_ORPHAN] = rsp_valid_i & ~pend;
    err_set[ERR_EMPTY]  = ret_mem_v & empty;
    err_set[ERR_PEND]   = ret_mem_v & ~empty & ~head.done & ~rsp_valid_i;
  end

  rvfi_mem_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (push),
    .push_dat_i   (push_dat),
    .pop_i        (pop),
    .cmpl_i       (cmpl),
    .cmpl_rdata_i (rsp_rdata_i),
    .full_o       (full),
    .empty_o      (empty),
    .pend_o       (pend),
    .head_o       (head)
  );

  always_comb begin
    addr_d  = '0;
    rmask_d = '0;
    wmask_d = '0;
    rdata_d = '0;
    wdata_d = '0;
    if (pop) begin
      addr_d  = head.addr;
      rmask_d = head.rmask;
      wmask_d = head.wmask;
      wdata_d = head.wdata;
      rdata_d = bypass ? (rsp_rdata_i & lane_mask(head.rmask)) : head.rdata;
    end
    cnt_d   = ret_valid_i ? cnt_q + 1'b1 : cnt_q;
    order_d = ret_valid_i ? cnt_q : order_q;
    err_d   = err_q | err_set;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      order_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= ret_valid_i;
      order_q <= order_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef RVFI_MEM_TRACKER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (err_set[ERR_OVF])    assert (1'b0) else $error("rvfi_mem_tracker: queue overflow");
      if (err_set[ERR_ORPHAN]) assert (1'b0) else $error("rvfi_mem_tracker: orphan response");
      if (err_set[ERR_EMPTY])  assert (1'b0) else $error("rvfi_mem_tracker: retire on empty queue");
      if (err_set[ERR_PEND])   assert (1'b0) else $error("rvfi_mem_tracker: retire with head pending");
    end
  end
`else
  // Error reporting relies on the sticky err bits alone.
`endif

  assign rvfi_valid_o     = valid_q;
  assign rvfi_order_o     = order_q;
  assign rvfi_mem_addr_o  = addr_q;
  assign rvfi_mem_rmask_o = rmask_q;
  assign rvfi_mem_wmask_o = wmask_q;
  assign rvfi_mem_rdata_o = rdata_q;
  assign rvfi_mem_wdata_o = wdata_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_rvfi_mem_tracker.sv
// Directed + randomized bench for rvfi_mem_tracker against a transaction-level queue model.
module tb_rvfi_mem_tracker;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid, req_ready, req_rd;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        rsp_valid, ret_valid, ret_mem;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_addr, rvfi_rdata, rvfi_wdata;
  logic [3:0]  rvfi_rmask, rvfi_wmask, err;

  always #5 clk = ~clk;

  rvfi_mem_tracker dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_valid_i      (req_valid),
    .req_ready_i      (req_ready),
    .req_rd_i         (req_rd),
    .req_addr_i       (req_addr),
    .req_be_i         (req_be),
    .req_wdata_i      (req_wdata),
    .rsp_valid_i      (rsp_valid),
    .rsp_rdata_i      (rsp_rdata),
    .ret_valid_i      (ret_valid),
    .ret_mem_i        (ret_mem),
    .rvfi_valid_o     (rvfi_valid),
    .rvfi_order_o     (rvfi_order),
    .rvfi_mem_addr_o  (rvfi_addr),
    .rvfi_mem_rmask_o (rvfi_rmask),
    .rvfi_mem_wmask_o (rvfi_wmask),
    .rvfi_mem_rdata_o (rvfi_rdata),
    .rvfi_mem_wdata_o (rvfi_wdata),
    .err_o            (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rm, wm;
    logic [31:0] rd, wd;
    bit          done;
  } ment_t;

  ment_t       mq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] m_cnt, e_order;
  logic        e_valid;
  logic [31:0] e_addr, e_rdata, e_wdata;
  logic [3:0]  e_rm, e_wm, e_err;

  function automatic logic [31:0] bytes_of(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic bit has_pending();
    foreach (mq[i]) if (!mq[i].done) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the registered outputs produced by the current inputs at the next edge.
  task automatic model();
    int    pend_idx;
    bit    popped, rsp_used;
    ment_t ent;
    if (!resetn) begin
      mq.delete();
      m_cnt = '0; e_order = '0; e_valid = 1'b0; e_err = '0;
      e_addr = '0; e_rm = '0; e_wm = '0; e_rdata = '0; e_wdata = '0;
      return;
    end
    pend_idx = -1;
    popped   = 1'b0;
    rsp_used = 1'b0;
    for (int i = 0; i < mq.size(); i++) if (!mq[i].done) begin pend_idx = i; break; end
    e_valid = ret_valid;
    e_addr = '0; e_rm = '0; e_wm = '0; e_rdata = '0; e_wdata = '0;
    if (ret_valid) begin e_order = m_cnt; m_cnt = m_cnt + 1; end
    if (ret_valid && ret_mem) begin
      if (mq.size() == 0) e_err[2] = 1'b1;
      else if (mq[0].done || rsp_valid) begin
        ent = mq.pop_front();
        popped = 1'b1;
        if (!ent.done) begin ent.rd = bytes_of(rsp_rdata, ent.rm); rsp_used = 1'b1; end
        e_addr = ent.addr; e_rm = ent.rm; e_wm = ent.wm; e_rdata = ent.rd; e_wdata = ent.wd;
      end else e_err[3] = 1'b1;
    end
    if (rsp_valid && !rsp_used) begin
      if (pend_idx < 0) e_err[1] = 1'b1;
      else begin
        if (popped) pend_idx = pend_idx - 1;
        mq[pend_idx].rd   = bytes_of(rsp_rdata, mq[pend_idx].rm);
        mq[pend_idx].done = 1'b1;
      end
    end
    if (req_valid && req_ready) begin
      if (mq.size() >= 4) e_err[0] = 1'b1;
      else begin
        ent.addr = {req_addr[31:2], 2'b00};
        ent.rm   = req_rd ? req_be : 4'h0;
        ent.wm   = req_rd ? 4'h0 : req_be;
        ent.rd   = '0;
        ent.wd   = req_rd ? '0 : bytes_of(req_wdata, req_be);
        ent.done = !req_rd;
        mq.push_back(ent);
      end
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("valid", 64'(rvfi_valid), 64'(e_valid));
    chk("order", rvfi_order, e_order);
    chk("addr", 64'(rvfi_addr), 64'(e_addr));
    chk("rmask", 64'(rvfi_rmask), 64'(e_rm));
    chk("wmask", 64'(rvfi_wmask), 64'(e_wm));
    chk("rdata", 64'(rvfi_rdata), 64'(e_rdata));
    chk("wdata", 64'(rvfi_wdata), 64'(e_wdata));
    chk("err", 64'(err), 64'(e_err));
  endtask

  task automatic idle();
    req_valid = 1'b0; req_ready = 1'b1; req_rd = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; rsp_valid = 1'b0; rsp_rdata = '0; ret_valid = 1'b0; ret_mem = 1'b0;
  endtask

  task automatic req(input logic rd, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    req_valid = 1'b1; req_ready = 1'b1; req_rd = rd; req_addr = a; req_be = be; req_wdata = wd;
  endtask

  task automatic do_reset();
    idle(); resetn = 1'b0; step(); resetn = 1'b1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    step(); step();
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_order", rvfi_order, 64'h0);
    resetn = 1'b1;

    // Store then retire two cycles later
    req(1'b0, 32'h100, 4'hF, 32'hDEADBEEF); step();
    idle(); step(); step();
    ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("st_wmask", 64'(rvfi_wmask), 64'hF);
    chk("st_addr", 64'(rvfi_addr), 64'h100);
    chk("st_wdata", 64'(rvfi_wdata), 64'hDEADBEEF);
    chk("st_rmask", 64'(rvfi_rmask), 64'h0);
    chk("st_order", rvfi_order, 64'h0);

    // Unaligned single-byte load
    req(1'b1, 32'h203, 4'h8, 32'h0); step();
    idle(); rsp_valid = 1'b1; rsp_rdata = 32'hAABBCCDD; step();
    idle(); ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("ld_addr", 64'(rvfi_addr), 64'h200);
    chk("ld_rmask", 64'(rvfi_rmask), 64'h8);
    chk("ld_rdata", 64'(rvfi_rdata), 64'hAA000000);

    // Response and retire in the same cycle
    req(1'b1, 32'h40, 4'hF, 32'h0); step();
    idle(); step();
    rsp_valid = 1'b1; rsp_rdata = 32'h12345678; ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("byp_rdata", 64'(rvfi_rdata), 64'h12345678);
    chk("byp_err", 64'(err), 64'h0);

    // Randomized legal traffic, including pushes at full with a same-cycle pop
    for (int c = 0; c < 400; c++) begin
      idle();
      rsp_valid = has_pending() && ($urandom_range(0, 2) == 0);
      rsp_rdata = $urandom;
      ret_valid = $urandom_range(0, 1) == 1;
      ret_mem   = ret_valid && (mq.size() > 0) && (mq[0].done || rsp_valid) && ($urandom_range(0, 3) != 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_ready = $urandom_range(0, 3) != 0;
      if (mq.size() >= 4 && !ret_mem) req_ready = 1'b0;
      req_rd    = $urandom_range(0, 1) == 1;
      req_addr  = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
      step();
    end
    idle(); step();
    chk("rand_err", 64'(err), 64'h0);

    // Five transfers into a four-deep queue
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(1'b0, 32'h1000 + 32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i)); step();
    end
    idle(); step();
    chk("ovf_err", 64'(err), 64'h1);
    for (int i = 0; i < 4; i++) begin
      idle(); ret_valid = 1'b1; ret_mem = 1'b1; step();
      chk("ovf_drain_addr", 64'(rvfi_addr), 64'(32'h1000 + 32'(i * 4)));
    end
    idle(); step();

    // Retire on an empty queue
    do_reset();
    ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("empty_err", 64'(err), 64'h4);
    chk("empty_rmask", 64'(rvfi_rmask), 64'h0);

    // Head pending at retire, then an orphan response
    do_reset();
    req(1'b1, 32'h300, 4'h3, 32'h0); step();
    idle(); ret_valid = 1'b1; ret_mem = 1'b1; step();
    idle(); rsp_valid = 1'b1; rsp_rdata = 32'h55667788; step();
    idle(); rsp_valid = 1'b1; rsp_rdata = 32'h11111111; step();
    idle(); ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("pend_err", 64'(err), 64'hA);
    chk("pend_rdata", 64'(rvfi_rdata), 64'h7788);

    // Load into an empty queue while retiring
    do_reset();
    req(1'b1, 32'h400, 4'hF, 32'h0); ret_valid = 1'b1; ret_mem = 1'b1; step();
    idle(); rsp_valid = 1'b1; rsp_rdata = 32'h0BADF00D; step();
    idle(); ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("ldempty_rdata", 64'(rvfi_rdata), 64'h0BADF00D);

    // Reset discards queued stores
    do_reset();
    req(1'b0, 32'h500, 4'hF, 32'h1); step();
    req(1'b0, 32'h504, 4'hF, 32'h2); step();
    do_reset();
    ret_valid = 1'b1; ret_mem = 1'b1; step(); idle();
    chk("rst_err", 64'(err), 64'h4);
    chk("rst_order", rvfi_order, 64'h0);
    chk("rst_valid", 64'(rvfi_valid), 64'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
